// File: rtl/reg_file_pkg.sv
// Shared widths, types and constants for the register-file scoreboard.
package reg_file_pkg;

   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned CNT_W     = 2;
   localparam int unsigned STALL_W   = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [CNT_W-1:0]     sb_cnt_t;

   localparam reg_idx_t REGISTER_X0 = reg_idx_t'(0);
   localparam sb_cnt_t  MAX_PENDING = sb_cnt_t'((1 << CNT_W) - 1);

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Decode-issue handshake, writeback retire and flush bundle.
interface reg_file_scoreboard_if;
   import reg_file_pkg::*;

   logic     issue_valid;
   logic     issue_ready;
   reg_idx_t issue_rs1;
   reg_idx_t issue_rs2;
   reg_idx_t issue_rd;
   logic     issue_uses_rs1;
   logic     issue_uses_rs2;
   logic     issue_writes_rd;
   logic     wb_valid;
   reg_idx_t wb_rd;
   logic     flush;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd,
             issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
             wb_valid, wb_rd, flush,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd,
             issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
             wb_valid, wb_rd, flush,
      output issue_ready
   );

endinterface

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
module sb_counter
   import reg_file_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    inc,
   input  logic    dec,
   input  logic    clr,
   output sb_cnt_t cnt,
   output sb_cnt_t eff,
   output logic    at_max
);

   logic hit;

   // A writeback only retires something when a write is actually pending.
   assign hit    = dec & (cnt != '0);
   assign eff    = cnt - sb_cnt_t'(hit);
   assign at_max = (eff == MAX_PENDING);

   // Count register: flush clears, otherwise retire then add the new issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else begin
         cnt <= eff + sb_cnt_t'(inc);
      end
   end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Scoreboard gating decode issue on outstanding register writes.
module reg_file_scoreboard
   import reg_file_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   reg_file_scoreboard_if.slave      sb,
   output logic [NUM_REGS-1:0]       busy_vec,
   output logic                      underflow_err,
   output logic [STALL_W-1:0]        stall_cycles
);

   sb_cnt_t             cnt_arr [NUM_REGS];
   sb_cnt_t             eff_arr [NUM_REGS];
   logic [NUM_REGS-1:0] at_max_vec;
   logic [NUM_REGS-1:1] inc_vec;
   logic [NUM_REGS-1:1] dec_vec;
   logic                raw_hazard;
   logic                sat_hazard;
   logic                fire;
   logic                stall;
   logic                underflow_hit;

   // x0 is hardwired: never pending, never saturates.
   assign cnt_arr[0]    = '0;
   assign eff_arr[0]    = '0;
   assign at_max_vec[0] = 1'b0;
   assign busy_vec[0]   = 1'b0;

   // Per-register index decode and counter instance for x1..x31.
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      assign dec_vec[g]  = sb.wb_valid & (sb.wb_rd == reg_idx_t'(g));
      assign inc_vec[g]  = fire & sb.issue_writes_rd & (sb.issue_rd == reg_idx_t'(g));
      assign busy_vec[g] = (cnt_arr[g] != '0);

      sb_counter u_cnt (
         .clk    (clk),
         .reset  (reset),
         .inc    (inc_vec[g]),
         .dec    (dec_vec[g]),
         .clr    (sb.flush),
         .cnt    (cnt_arr[g]),
         .eff    (eff_arr[g]),
         .at_max (at_max_vec[g])
      );
   end

   // Hazard and ready: same-cycle writeback already folded into eff.
   always_comb begin
      raw_hazard     = (sb.issue_uses_rs1 & (eff_arr[sb.issue_rs1] != '0))
                     | (sb.issue_uses_rs2 & (eff_arr[sb.issue_rs2] != '0));
      sat_hazard     = sb.issue_writes_rd & (sb.issue_rd != REGISTER_X0)
                     & at_max_vec[sb.issue_rd];
      sb.issue_ready = ~sb.flush & ~raw_hazard & ~sat_hazard;
   end

   assign fire          = sb.issue_valid & sb.issue_ready;
   assign stall         = sb.issue_valid & ~sb.issue_ready & ~sb.flush;
   assign underflow_hit = sb.wb_valid & (sb.wb_rd != REGISTER_X0)
                        & (cnt_arr[sb.wb_rd] == '0) & ~sb.flush;

   // Sticky underflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         underflow_err <= 1'b0;
      end else if (underflow_hit) begin
         underflow_err <= 1'b1;
      end
   end

   // Free-running stall counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (stall) begin
         stall_cycles <= stall_cycles + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed and random checks of reg_file_scoreboard against a counting model.
module tb_reg_file_scoreboard;
   import reg_file_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic [NUM_REGS-1:0] busy_vec;
   logic                underflow_err;
   logic [31:0]         stall_cycles;

   reg_file_scoreboard_if sb_if ();

   reg_file_scoreboard dut (
      .clk           (clk),
      .reset         (reset),
      .sb            (sb_if),
      .busy_vec      (busy_vec),
      .underflow_err (underflow_err),
      .stall_cycles  (stall_cycles)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          pend [NUM_REGS];
   bit          exp_err = 1'b0;
   int unsigned exp_stall = 0;
   bit          last_stall = 1'b0;

   // Pending writes to r as seen this cycle, after any same-cycle retire.
   function automatic int eff_of(input int r);
      int p;
      if (r == 0) return 0;
      p = pend[r];
      if (sb_if.wb_valid && int'(sb_if.wb_rd) == r && p > 0) p--;
      return p;
   endfunction

   function automatic bit model_ready();
      if (sb_if.flush) return 1'b0;
      if (sb_if.issue_uses_rs1 && eff_of(int'(sb_if.issue_rs1)) > 0) return 1'b0;
      if (sb_if.issue_uses_rs2 && eff_of(int'(sb_if.issue_rs2)) > 0) return 1'b0;
      if (sb_if.issue_writes_rd && sb_if.issue_rd != 0 &&
          eff_of(int'(sb_if.issue_rd)) == 3) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_update(input bit rdy);
      int w;
      int d;
      if (reset) begin
         foreach (pend[i]) pend[i] = 0;
         exp_err   = 1'b0;
         exp_stall = 0;
      end else if (sb_if.flush) begin
         foreach (pend[i]) pend[i] = 0;
      end else begin
         w = int'(sb_if.wb_rd);
         d = int'(sb_if.issue_rd);
         if (sb_if.wb_valid && w != 0) begin
            if (pend[w] == 0) exp_err = 1'b1;
            else pend[w]--;
         end
         if (sb_if.issue_valid && rdy && sb_if.issue_writes_rd && d != 0) pend[d]++;
         if (sb_if.issue_valid && !rdy) exp_stall++;
      end
   endtask

   function automatic logic [NUM_REGS-1:0] exp_busy();
      logic [NUM_REGS-1:0] b;
      b = '0;
      for (int i = 1; i < NUM_REGS; i++) b[i] = (pend[i] > 0);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check ready before the edge, registered outputs after it.
   task automatic cycle(input string tag);
      bit rdy;
      #2;
      rdy = 1'b0;
      if (!reset) begin
         rdy = model_ready();
         chk({tag, "/ready"}, 32'(sb_if.issue_ready), 32'(rdy));
      end
      last_stall = !reset && sb_if.issue_valid && !rdy && !sb_if.flush;
      @(posedge clk);
      model_update(rdy);
      #1;
      chk({tag, "/busy"},  busy_vec, exp_busy());
      chk({tag, "/err"},   32'(underflow_err), 32'(exp_err));
      chk({tag, "/stall"}, stall_cycles, exp_stall);
   endtask

   task automatic drv(input bit v, input int rs1, input int rs2, input int rd,
                      input bit u1, input bit u2, input bit w,
                      input bit wbv, input int wbrd, input bit fl);
      sb_if.issue_valid     = v;
      sb_if.issue_rs1       = reg_idx_t'(rs1);
      sb_if.issue_rs2       = reg_idx_t'(rs2);
      sb_if.issue_rd        = reg_idx_t'(rd);
      sb_if.issue_uses_rs1  = u1;
      sb_if.issue_uses_rs2  = u2;
      sb_if.issue_writes_rd = w;
      sb_if.wb_valid        = wbv;
      sb_if.wb_rd           = reg_idx_t'(wbrd);
      sb_if.flush           = fl;
   endtask

   initial begin
      int r;
      foreach (pend[i]) pend[i] = 0;
      reset = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("reset");
      cycle("reset");
      reset = 1'b0;
      cycle("idle");
      chk("reset_state_busy", busy_vec, 32'd0);

      // Back-to-back RAW, four stalled cycles, then same-cycle release.
      drv(1, 0, 0, 5, 0, 0, 1, 0, 0, 0);
      cycle("raw_prod");
      chk("raw_busy5_set", 32'(busy_vec[5]), 32'd1);
      drv(1, 5, 0, 0, 1, 0, 0, 0, 0, 0);
      repeat (4) cycle("raw_stall");
      chk("stall_count4", stall_cycles, 32'd4);
      drv(1, 5, 0, 0, 1, 0, 0, 1, 5, 0);
      cycle("raw_release");
      chk("raw_busy5_clear", 32'(busy_vec[5]), 32'd0);

      // x0 never tracked; writeback to x0 is not an underflow.
      drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cycle("x0_write");
      drv(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      cycle("x0_read");
      chk("x0_busy0", 32'(busy_vec[0]), 32'd0);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cycle("x0_wb");
      chk("x0_no_underflow", 32'(underflow_err), 32'd0);

      // Saturation on x7, released by same-cycle writeback.
      drv(1, 0, 0, 7, 0, 0, 1, 0, 0, 0);
      repeat (3) cycle("sat_fill");
      cycle("sat_block");
      drv(1, 0, 0, 7, 0, 0, 1, 1, 7, 0);
      cycle("sat_wb");
      chk("sat_busy7", 32'(busy_vec[7]), 32'd1);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
      repeat (3) cycle("sat_drain");
      chk("sat_drained", 32'(busy_vec[7]), 32'd0);

      // Simultaneous issue and writeback on x9.
      drv(1, 0, 0, 9, 0, 0, 1, 0, 0, 0);
      cycle("sim_first");
      drv(1, 0, 0, 9, 0, 0, 1, 1, 9, 0);
      cycle("sim_both");
      chk("sim_busy9", 32'(busy_vec[9]), 32'd1);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      cycle("sim_drain");

      // Flush discards counts and same-cycle writeback; late wb underflows.
      drv(1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
      repeat (2) cycle("fl_fill3");
      drv(1, 0, 0, 4, 0, 0, 1, 0, 0, 0);
      cycle("fl_fill4");
      drv(1, 3, 0, 3, 1, 0, 1, 1, 3, 1);
      cycle("flush");
      chk("flush_busy", busy_vec, 32'd0);
      chk("flush_no_err", 32'(underflow_err), 32'd0);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
      cycle("late_wb");
      chk("late_wb_err", 32'(underflow_err), 32'd1);

      // Reset in the middle of a stall.
      drv(1, 0, 0, 6, 0, 0, 1, 0, 0, 0);
      cycle("rst_prod");
      drv(1, 6, 0, 0, 1, 0, 0, 0, 0, 0);
      repeat (2) cycle("rst_stall");
      reset = 1'b1;
      drv(1, 6, 0, 6, 1, 0, 1, 1, 6, 0);
      cycle("rst_mid");
      chk("rst_busy", busy_vec, 32'd0);
      chk("rst_err", 32'(underflow_err), 32'd0);
      chk("rst_stall", stall_cycles, 32'd0);
      reset = 1'b0;

      // Random traffic on a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 149) == 0);
         if (!last_stall) begin
            sb_if.issue_valid     = ($urandom_range(0, 3) != 0);
            sb_if.issue_rs1       = reg_idx_t'($urandom_range(0, 7));
            sb_if.issue_rs2       = reg_idx_t'($urandom_range(0, 7));
            sb_if.issue_rd        = reg_idx_t'($urandom_range(0, 7));
            sb_if.issue_uses_rs1  = ($urandom_range(0, 1) != 0);
            sb_if.issue_uses_rs2  = ($urandom_range(0, 2) == 0);
            sb_if.issue_writes_rd = ($urandom_range(0, 3) != 0);
         end
         r = int'($urandom_range(0, 7));
         sb_if.wb_rd    = reg_idx_t'(r);
         sb_if.wb_valid = (pend[r] > 0) ? ($urandom_range(0, 1) != 0)
                                        : ($urandom_range(0, 39) == 0);
         sb_if.flush    = ($urandom_range(0, 24) == 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
